// File: rtl/adder_sum_accum.sv
// Sequential sink for the adder benchmark: sums WINDOW accepted samples and
// presents each window total, with a sticky carry-out flag, on a held output handshake.
module adder_sum_accum #(
  parameter int SUM_WIDTH = 3,
  parameter int WINDOW    = 4,
  parameter int ACC_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SUM_WIDTH-1:0] in_sum,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_total,
  output logic                 out_ovf
);

  // state | meaning
  // ACCUM | accepting samples, in_ready=1, out_valid=0
  // HOLD  | window total presented, out_valid=1, in_ready=0
  localparam logic [0:0] S_ACCUM = 1'b0;
  localparam logic [0:0] S_HOLD  = 1'b1;
  localparam logic [7:0] LAST    = 8'(WINDOW - 1);

  logic [0:0]           r_state;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [7:0]           r_cnt;
  logic                 r_ovf;
  logic [ACC_WIDTH-1:0] r_total;
  logic                 r_out_ovf;

  logic [ACC_WIDTH:0]   w_sum;
  logic                 w_carry;
  logic                 w_xfer_in;
  logic                 w_xfer_out;
  logic                 w_last;

  // Extra top bit of the add captures the carry out of the accumulator width.
  assign w_sum      = {1'b0, r_acc} + (ACC_WIDTH + 1)'(in_sum);
  assign w_carry    = w_sum[ACC_WIDTH];
  assign w_xfer_in  = in_valid && (r_state == S_ACCUM);
  assign w_xfer_out = out_ready && (r_state == S_HOLD);
  assign w_last     = (r_cnt == LAST);

  // Handshake flags decode a single state flop, so they stay glitch-free.
  assign in_ready  = (r_state == S_ACCUM);
  assign out_valid = (r_state == S_HOLD);
  assign out_total = r_total;
  assign out_ovf   = r_out_ovf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_ACCUM;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_total   <= '0;
      r_out_ovf <= 1'b0;
    end else begin
      case (r_state)
        S_ACCUM: begin
          if (w_xfer_in) begin
            if (w_last) begin
              r_total   <= w_sum[ACC_WIDTH-1:0];
              r_out_ovf <= r_ovf | w_carry;
              r_acc     <= '0;
              r_ovf     <= 1'b0;
              r_cnt     <= '0;
              r_state   <= S_HOLD;
            end else begin
              r_acc <= w_sum[ACC_WIDTH-1:0];
              r_ovf <= r_ovf | w_carry;
              r_cnt <= 8'(r_cnt + 8'd1);
            end
          end
        end
        S_HOLD: begin
          if (w_xfer_out) begin
            r_state <= S_ACCUM;
          end
        end
        default: r_state <= S_ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_sum_accum.sv
// Directed-vector bench for adder_sum_accum across three parameterisations:
// default (W=4, A=16), narrow accumulator (A=4) and single-sample window (W=1).
module tb_adder_sum_accum;

  logic        clk = 1'b0;
  logic        reset;
  logic        v0, v1, v2;
  logic [2:0]  s0, s1, s2;
  logic        r0, r1, r2;
  logic        ir0, ir1, ir2;
  logic        ov0, ov1, ov2;
  logic        of0, of1, of2;
  logic [15:0] t0, t2;
  logic [3:0]  t1;

  adder_sum_accum #(.SUM_WIDTH(3), .WINDOW(4), .ACC_WIDTH(16)) u_dut0 (
    .clk(clk), .reset(reset), .in_valid(v0), .in_ready(ir0), .in_sum(s0),
    .out_valid(ov0), .out_ready(r0), .out_total(t0), .out_ovf(of0));

  adder_sum_accum #(.SUM_WIDTH(3), .WINDOW(4), .ACC_WIDTH(4)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(v1), .in_ready(ir1), .in_sum(s1),
    .out_valid(ov1), .out_ready(r1), .out_total(t1), .out_ovf(of1));

  adder_sum_accum #(.SUM_WIDTH(3), .WINDOW(1), .ACC_WIDTH(16)) u_dut2 (
    .clk(clk), .reset(reset), .in_valid(v2), .in_ready(ir2), .in_sum(s2),
    .out_valid(ov2), .out_ready(r2), .out_total(t2), .out_ovf(of2));

  always #5 clk = ~clk;

  typedef struct {
    int          dut;
    logic        vld;
    logic [2:0]  sum;
    logic        ordy;
    logic        e_ov;
    logic        e_ir;
    logic        chk;
    logic [15:0] e_tot;
    logic        e_ovf;
  } vec_t;

  vec_t tv[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int d, input logic vld, input logic [2:0] sum, input logic ordy);
    v0 = 1'b0; s0 = 3'd0; r0 = 1'b1;
    v1 = 1'b0; s1 = 3'd0; r1 = 1'b1;
    v2 = 1'b0; s2 = 3'd0; r2 = 1'b1;
    case (d)
      0: begin v0 = vld; s0 = sum; r0 = ordy; end
      1: begin v1 = vld; s1 = sum; r1 = ordy; end
      default: begin v2 = vld; s2 = sum; r2 = ordy; end
    endcase
  endtask

  task automatic check_dut(input string tag, input int d, input logic e_ov, input logic e_ir,
                           input logic do_tot, input logic [15:0] e_tot, input logic e_ovf);
    logic        a_ov, a_ir, a_of;
    logic [15:0] a_tot;
    case (d)
      0: begin a_ov = ov0; a_ir = ir0; a_tot = t0; a_of = of0; end
      1: begin a_ov = ov1; a_ir = ir1; a_tot = {12'd0, t1}; a_of = of1; end
      default: begin a_ov = ov2; a_ir = ir2; a_tot = t2; a_of = of2; end
    endcase
    chk({tag, " out_valid"}, {15'd0, a_ov}, {15'd0, e_ov});
    chk({tag, " in_ready"}, {15'd0, a_ir}, {15'd0, e_ir});
    if (do_tot) begin
      chk({tag, " out_total"}, a_tot, e_tot);
      chk({tag, " out_ovf"}, {15'd0, a_of}, {15'd0, e_ovf});
    end
  endtask

  task automatic add(input int d, input logic vld, input logic [2:0] sum, input logic ordy,
                     input logic e_ov, input logic e_ir, input logic c,
                     input logic [15:0] e_tot, input logic e_ovf);
    tv.push_back('{d, vld, sum, ordy, e_ov, e_ir, c, e_tot, e_ovf});
  endtask

  initial begin
    // 1,2,3,6 -> 12, released the cycle after
    add(0, 1, 1, 1, 0, 1, 0, 0, 0);
    add(0, 1, 2, 1, 0, 1, 0, 0, 0);
    add(0, 1, 3, 1, 0, 1, 0, 0, 0);
    add(0, 1, 6, 1, 1, 0, 1, 12, 0);
    add(0, 0, 0, 1, 0, 1, 0, 0, 0);
    // backpressure: 7x4 = 28 held for 5 cycles while in_valid pulses
    add(0, 1, 7, 0, 0, 1, 0, 0, 0);
    add(0, 1, 7, 0, 0, 1, 0, 0, 0);
    add(0, 1, 7, 0, 0, 1, 0, 0, 0);
    add(0, 1, 7, 0, 1, 0, 1, 28, 0);
    for (int i = 0; i < 5; i++) add(0, (i % 2 == 0), 7, 0, 1, 0, 1, 28, 0);
    add(0, 0, 0, 1, 0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 1, 0, 0, 0);
    // gapped input 5,x,x,2,x,1,4 -> 12
    add(0, 1, 5, 0, 0, 1, 0, 0, 0);
    add(0, 0, 7, 0, 0, 1, 0, 0, 0);
    add(0, 0, 7, 0, 0, 1, 0, 0, 0);
    add(0, 1, 2, 0, 0, 1, 0, 0, 0);
    add(0, 0, 7, 0, 0, 1, 0, 0, 0);
    add(0, 1, 1, 0, 0, 1, 0, 0, 0);
    add(0, 1, 4, 0, 1, 0, 1, 12, 0);
    add(0, 0, 0, 1, 0, 1, 0, 0, 0);
    // ACC_WIDTH=4: 28 mod 16 = 12 with overflow, then 1x4 = 4 clean
    add(1, 1, 7, 1, 0, 1, 0, 0, 0);
    add(1, 1, 7, 1, 0, 1, 0, 0, 0);
    add(1, 1, 7, 1, 0, 1, 0, 0, 0);
    add(1, 1, 7, 1, 1, 0, 1, 12, 1);
    add(1, 1, 1, 1, 0, 1, 0, 0, 0);
    add(1, 1, 1, 1, 0, 1, 0, 0, 0);
    add(1, 1, 1, 1, 0, 1, 0, 0, 0);
    add(1, 1, 1, 1, 0, 1, 0, 0, 0);
    add(1, 1, 1, 1, 1, 0, 1, 4, 0);
    add(1, 0, 0, 1, 0, 1, 0, 0, 0);
    // WINDOW=1: 3 then 5, one accept every 2 cycles
    add(2, 1, 3, 1, 1, 0, 1, 3, 0);
    add(2, 1, 5, 1, 0, 1, 0, 0, 0);
    add(2, 1, 5, 1, 1, 0, 1, 5, 0);
    add(2, 0, 0, 1, 0, 1, 0, 0, 0);

    reset = 1'b1;
    drive(0, 0, 0, 1);
    #3;
    check_dut("rst0", 0, 0, 1, 1, 0, 0);
    check_dut("rst1", 1, 0, 1, 1, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_dut("post_rst", 0, 0, 1, 1, 0, 0);

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].dut, tv[i].vld, tv[i].sum, tv[i].ordy);
      @(posedge clk);
      @(negedge clk);
      check_dut($sformatf("v%0d", i), tv[i].dut, tv[i].e_ov, tv[i].e_ir,
                tv[i].chk, tv[i].e_tot, tv[i].e_ovf);
    end

    // async reset after two samples of 4; out_total still shows the last 12
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 4, 1);
      @(posedge clk);
      @(negedge clk);
    end
    drive(0, 0, 0, 1);
    #2 reset = 1'b1;
    #1;
    check_dut("async_rst", 0, 0, 1, 1, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 1, 1);
      @(posedge clk);
      @(negedge clk);
    end
    check_dut("after_rst", 0, 1, 0, 1, 4, 0);
    drive(0, 0, 0, 1);
    @(posedge clk);
    @(negedge clk);
    check_dut("after_rst_rel", 0, 0, 1, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/adder_sum_accum.md
Name: adder_sum_accum

Overview:
- Downstream consumer of the registered adder benchmark stage's `sum` output.
- Accepts a stream of sums over a valid/ready handshake and accumulates WINDOW consecutive samples into a total.
- Presents each window total on a held output handshake with an overflow flag.
- Gives the arithmetic benchmarks a sequential sink so that adder outputs are not optimised away.

Parameters:
- SUM_WIDTH, 3, width of incoming sum (adder width + 1 carry bit).
- WINDOW, 4, number of samples per total; legal range 1..255.
- ACC_WIDTH, 16, width of accumulator and output total; must be >= SUM_WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_sum is valid this cycle.
- in_ready  output  1  block can accept in_sum this cycle.
- in_sum  input  SUM_WIDTH  unsigned sum from the adder stage.
- out_valid  output  1  out_total/out_ovf are valid.
- out_ready  input  1  consumer accepts the output this cycle.
- out_total  output  ACC_WIDTH  sum of WINDOW samples, modulo 2^ACC_WIDTH.
- out_ovf  output  1  at least one carry out of ACC_WIDTH occurred within this window.

Behaviour:
- Reset (async assert, removal synchronous to clk):
  - state=ACCUM, acc=0, count=0, ovf=0.
  - out_valid=0, out_total=0, out_ovf=0, in_ready=1 (registered).
- Input transfer: occurs on a rising edge with in_valid && in_ready. in_sum is zero-extended to ACC_WIDTH+1 for the add.
- State ACCUM (in_ready=1, out_valid=0):
  - On transfer with count < WINDOW-1: acc <= (acc + in_sum) mod 2^ACC_WIDTH; ovf |= carry; count++.
  - On transfer with count == WINDOW-1:
    - out_total <= (acc + in_sum) mod 2^ACC_WIDTH; out_ovf <= ovf | carry.
    - acc <= 0; ovf <= 0; count <= 0; state <= HOLD.
  - No transfer: all state holds.
- State HOLD (out_valid=1, in_ready=0):
  - out_total/out_ovf stable until the output transfer.
  - On out_valid && out_ready: state <= ACCUM, out_valid <= 0, in_ready <= 1 on the next cycle.
  - No input is accepted in HOLD regardless of in_valid.
- Latency:
  - out_valid rises on the clock edge that accepts the final sample of a window, i.e. visible 1 cycle after that sample is presented.
  - Minimum window period is WINDOW+1 cycles: WINDOW accepts plus 1 output cycle.
- in_ready and out_valid are pure functions of state: mutually exclusive and both registered. No combinational path from in_valid to in_ready, or from out_ready to out_valid.
- WINDOW=1: every accepted sample goes directly to HOLD; out_total = zero-extended in_sum.
- Carry/wrap: acc wraps modulo 2^ACC_WIDTH. The ovf flag is sticky within a window and cleared at window completion.
- Ignored inputs: out_ready while out_valid=0 has no effect. in_valid while in_ready=0 has no effect; upstream must hold data.
- Reset mid-window or in HOLD: partial accumulation and any pending total are discarded immediately, and outputs take reset values asynchronously.
- All outputs are glitch-free registered values.

Test Plan:
- Reset then WINDOW=4, in_sum=1,2,3,6 on consecutive cycles with out_ready=1:
  - out_valid=1 in the cycle after the 4th accept, with out_total=12 and out_ovf=0.
  - in_ready returns to 1 in the following cycle.
- Backpressure: complete a window with sums 7,7,7,7 and hold out_ready=0 for 5 cycles:
  - out_valid stays 1, out_total=28, in_ready=0, and in_valid pulses are ignored.
  - Raise out_ready: one transfer, then out_valid=0.
- Overflow with ACC_WIDTH=4, WINDOW=4, sums 7,7,7,7 (total 28):
  - out_total=12 (28 mod 16) and out_ovf=1.
  - The next window 1,1,1,1 gives out_total=4 and out_ovf=0.
- Gapped input: in_valid toggles 1,0,0,1,0,1,1 with sums 5,x,x,2,x,1,4:
  - Only valid beats count; out_total=12.
- WINDOW=1, sums 3,5 back to back with out_ready=1:
  - Outputs are 3 and then 5.
  - in_ready=0 in each HOLD cycle, giving an accept period of 2 cycles.
- Async reset asserted mid-cycle after 2 of 4 samples (sums 4,4):
  - Outputs clear immediately.
  - After release, sums 1,1,1,1 yield out_total=4, not 12.
